// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU command sequencer: the ALU
//               opcode constants, the opcode and status widths, and the
//               sequencer FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_OP_W   = 4;
    localparam int c_STAT_W = 4;

    localparam logic [c_OP_W-1:0] c_OP_NOOP = 4'd0;
    localparam logic [c_OP_W-1:0] c_OP_ADDR = 4'd1;
    localparam logic [c_OP_W-1:0] c_OP_SUBT = 4'd2;
    localparam logic [c_OP_W-1:0] c_OP_INCL = 4'd3;
    localparam logic [c_OP_W-1:0] c_OP_INCR = 4'd4;
    localparam logic [c_OP_W-1:0] c_OP_DECL = 4'd5;
    localparam logic [c_OP_W-1:0] c_OP_DECR = 4'd6;
    localparam logic [c_OP_W-1:0] c_OP_LAND = 4'd7;
    localparam logic [c_OP_W-1:0] c_OP_LOR  = 4'd8;
    localparam logic [c_OP_W-1:0] c_OP_LNOT = 4'd9;
    localparam logic [c_OP_W-1:0] c_OP_SHTL = 4'd10;
    localparam logic [c_OP_W-1:0] c_OP_ROTR = 4'd11;
    localparam logic [c_OP_W-1:0] c_OP_GOL  = 4'd12;
    localparam logic [c_OP_W-1:0] c_OP_GOR  = 4'd13;
    localparam logic [c_OP_W-1:0] c_OP_OUT0 = 4'd14;
    localparam logic [c_OP_W-1:0] c_OP_OUT1 = 4'd15;

    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_OPER = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_if
// Description : Bundle of every non-clock signal of the ALU sequencer.
//               master : command source / ALU / debug side
//               slave  : the sequencer itself
//               Groups: cmd_* (command handshake), ld_* (direct register
//               load), alu_* (ALU drive and return), done/res_out/stat_out
//               (completion report), dbg_* (register file peek).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if
    import alu_pkg::*;
#(
    parameter int M  = 8,
    parameter int RW = 2
) ();

    logic                cmd_valid;
    logic                cmd_ready;
    logic [c_OP_W-1:0]   cmd_op;
    logic [RW-1:0]       cmd_rd;
    logic [RW-1:0]       cmd_ra;
    logic [RW-1:0]       cmd_rb;

    logic                ld_valid;
    logic                ld_ready;
    logic [RW-1:0]       ld_addr;
    logic [M-1:0]        ld_data;

    logic [c_OP_W-1:0]   alu_op;
    logic [M-1:0]        alu_a;
    logic [M-1:0]        alu_b;
    logic [M-1:0]        alu_res;
    logic [c_STAT_W-1:0] alu_stat;

    logic                done;
    logic [M-1:0]        res_out;
    logic [c_STAT_W-1:0] stat_out;

    logic [RW-1:0]       dbg_addr;
    logic [M-1:0]        dbg_data;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb,
        output ld_valid, ld_addr, ld_data,
        output alu_res, alu_stat, dbg_addr,
        input  cmd_ready, ld_ready, alu_op, alu_a, alu_b,
        input  done, res_out, stat_out, dbg_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb,
        input  ld_valid, ld_addr, ld_data,
        input  alu_res, alu_stat, dbg_addr,
        output cmd_ready, ld_ready, alu_op, alu_a, alu_b,
        output done, res_out, stat_out, dbg_data
    );

endinterface
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile
// Description : NREG x M operand register file. Synchronous active-high
//               clear of every entry, one write port, three combinational
//               read ports (left operand, right operand, debug).
//   clk, reset               : clock and synchronous clear
//   i_we/i_waddr/i_wdata     : write port
//   i_ra_addr -> o_ra_data   : read port A
//   i_rb_addr -> o_rb_data   : read port B
//   i_dbg_addr -> o_dbg_data : debug read port
// Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile
    import alu_pkg::*;
#(
    parameter int M    = 8,
    parameter int NREG = 4,
    parameter int RW   = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          i_we,
    input  wire logic [RW-1:0] i_waddr,
    input  wire logic [M-1:0]  i_wdata,
    input  wire logic [RW-1:0] i_ra_addr,
    output logic      [M-1:0]  o_ra_data,
    input  wire logic [RW-1:0] i_rb_addr,
    output logic      [M-1:0]  o_rb_data,
    input  wire logic [RW-1:0] i_dbg_addr,
    output logic      [M-1:0]  o_dbg_data
);

    logic [M-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_ra_data  = r_mem[i_ra_addr];
    assign o_rb_data  = r_mem[i_rb_addr];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Single-issue command sequencer for the 8-bit ALU. Accepts one
//               command at a time, fetches operands from its register file,
//               presents them to the ALU for exactly one cycle, then writes
//               the result back and reports result and status.
//   clk   : system clock, rising edge
//   reset : synchronous active-high; aborts any command in flight and
//           clears the register file
//   bus   : alu_sequencer_if.slave (command, load, ALU, report, debug)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int M    = 8,
    parameter int NREG = 4,
    parameter int RW   = 2
) (
    input wire logic       clk,
    input wire logic       reset,
    alu_sequencer_if.slave bus
);

    state_t              r_state;
    state_t              w_next_state;

    logic [c_OP_W-1:0]   r_op;
    logic [RW-1:0]       r_rd;
    logic [RW-1:0]       r_ra;
    logic [RW-1:0]       r_rb;
    logic [M-1:0]        r_a;
    logic [M-1:0]        r_b;
    logic [M-1:0]        r_res;
    logic [c_STAT_W-1:0] r_stat;

    logic                w_cmd_ready;
    logic                w_ld_ready;
    logic                w_done;
    logic [c_OP_W-1:0]   w_alu_op;
    logic [M-1:0]        w_alu_a;
    logic [M-1:0]        w_alu_b;

    logic                w_cmd_fire;
    logic                w_ld_fire;
    logic                w_wb_write;
    logic                w_we;
    logic [RW-1:0]       w_waddr;
    logic [M-1:0]        w_wdata;
    logic [M-1:0]        w_ra_data;
    logic [M-1:0]        w_rb_data;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs. The ALU only sees a real
    // opcode and operands during EXEC; at all other times it is fed a
    // Noop with zero operands so it never updates its flags spuriously.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_cmd_ready  = 1'b0;
        w_ld_ready   = 1'b0;
        w_done       = 1'b0;
        w_alu_op     = c_OP_NOOP;
        w_alu_a      = '0;
        w_alu_b      = '0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                // A pending command always wins over a load.
                w_ld_ready  = !bus.cmd_valid;
                if (bus.cmd_valid) begin
                    w_next_state = ST_OPER;
                end
            end
            ST_OPER: begin
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                w_alu_op     = r_op;
                w_alu_a      = r_a;
                w_alu_b      = r_b;
                w_next_state = ST_WB;
            end
            ST_WB: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_cmd_fire = bus.cmd_valid && w_cmd_ready;
    assign w_ld_fire  = bus.ld_valid && w_ld_ready;
    assign w_wb_write = (r_state == ST_WB) && (r_op != c_OP_NOOP);

    // Writeback and load are mutually exclusive (load only in IDLE),
    // so a simple priority mux shares the single write port.
    assign w_we    = w_wb_write || w_ld_fire;
    assign w_waddr = w_wb_write ? r_rd  : bus.ld_addr;
    assign w_wdata = w_wb_write ? r_res : bus.ld_data;

    // ------------------------------------------------------------------
    // Command latch, operand registers and report registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op   <= c_OP_NOOP;
            r_rd   <= '0;
            r_ra   <= '0;
            r_rb   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_stat <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_op <= bus.cmd_op;
                r_rd <= bus.cmd_rd;
                r_ra <= bus.cmd_ra;
                r_rb <= bus.cmd_rb;
            end
            // Operands are read here, after any previous writeback has
            // landed, so back-to-back dependent commands need no bypass.
            if (r_state == ST_OPER) begin
                r_a <= w_ra_data;
                r_b <= w_rb_data;
            end
            if (r_state == ST_EXEC) begin
                r_res <= bus.alu_res;
            end
            // The ALU registers its flags at the end of EXEC, so they are
            // only valid to sample one cycle later.
            if (r_state == ST_WB) begin
                r_stat <= bus.alu_stat;
            end
        end
    end

    alu_regfile #(
        .M    (M),
        .NREG (NREG),
        .RW   (RW)
    ) u_regfile (
        .clk        (clk),
        .reset      (reset),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_ra_addr  (r_ra),
        .o_ra_data  (w_ra_data),
        .i_rb_addr  (r_rb),
        .o_rb_data  (w_rb_data),
        .i_dbg_addr (bus.dbg_addr),
        .o_dbg_data (bus.dbg_data)
    );

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.ld_ready  = w_ld_ready;
    assign bus.done      = w_done;
    assign bus.alu_op    = w_alu_op;
    assign bus.alu_a     = w_alu_a;
    assign bus.alu_b     = w_alu_b;
    assign bus.res_out   = r_res;
    assign bus.stat_out  = r_stat;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer. Provides a
//               behavioural 8-bit ALU (combinational result, flags
//               registered on non-Noop ops, cleared by reset) and a
//               register-file reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_sequencer_if #(.M(8), .RW(2)) bus ();

    alu_sequencer #(.M(8), .NREG(4), .RW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mreg [4];
    logic [3:0] mflags;

    // ALU behaviour: returns {C,N,Z,O, result[7:0]}.
    function automatic logic [11:0] alu_eval(input logic [3:0] op,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
        logic [8:0] s;
        logic       c;
        logic       o;
        s = 9'd0;
        c = 1'b0;
        o = 1'b0;
        case (op)
            4'd1:  begin s = {1'b0, a} + {1'b0, b}; c = s[8];
                         o = (a[7] == b[7]) && (s[7] != a[7]); end
            4'd2:  begin s = {1'b0, a} - {1'b0, b}; c = s[8];
                         o = (a[7] != b[7]) && (s[7] != a[7]); end
            4'd3:  begin s = {1'b0, a} + 9'd1; c = s[8]; end
            4'd4:  begin s = {1'b0, b} + 9'd1; c = s[8]; end
            4'd5:  begin s = {1'b0, a} - 9'd1; c = s[8]; end
            4'd6:  begin s = {1'b0, b} - 9'd1; c = s[8]; end
            4'd7:  s = {1'b0, a & b};
            4'd8:  s = {1'b0, a | b};
            4'd9:  s = {1'b0, ~a};
            4'd10: begin s = {a, 1'b0}; c = a[7]; end
            4'd11: begin s = {1'b0, a[0], a[7:1]}; c = a[0]; end
            4'd12: s = {1'b0, a};
            4'd13: s = {1'b0, b};
            4'd14: s = 9'h000;
            4'd15: s = 9'h0FF;
            default: s = 9'h000;
        endcase
        return {c, s[7], (s[7:0] == 8'd0), o, s[7:0]};
    endfunction

    logic [11:0] alu_w;
    logic [3:0]  alu_flags_r;
    assign alu_w        = alu_eval(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus.alu_res  = alu_w[7:0];
    assign bus.alu_stat = alu_flags_r;
    always @(posedge clk) begin
        if (reset)                alu_flags_r <= 4'h0;
        else if (bus.alu_op != 0) alu_flags_r <= alu_w[11:8];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        bus.dbg_addr = idx;
        #1;
        check(tag, bus.dbg_data, exp);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 4; i++) check_reg(tag, 2'(i), mreg[i]);
    endtask

    // All tasks start and end in the low phase just after a negedge.
    task automatic do_load(input logic [1:0] addr, input logic [7:0] data);
        int guard;
        guard = 0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = addr;
        bus.ld_data  = data;
        #1;
        while (!bus.ld_ready && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        check("ld_wait", (guard < 20), 1);
        @(posedge clk);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        mreg[addr]   = data;
    endtask

    task automatic do_cmd(input logic [3:0] op, input logic [1:0] rd,
                          input logic [1:0] ra, input logic [1:0] rb);
        int          guard;
        logic [11:0] e;
        logic [7:0]  a;
        logic [7:0]  b;
        guard = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_ra    = ra;
        bus.cmd_rb    = rb;
        #1;
        while (!bus.cmd_ready && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        check("cmd_wait", (guard < 20), 1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1;
        a = mreg[ra];
        b = mreg[rb];
        e = alu_eval(op, a, b);
        check("oper_done", bus.done, 0);
        check("oper_alu_op", bus.alu_op, 0);
        check("oper_cmd_ready", bus.cmd_ready, 0);
        @(negedge clk); #1;
        check("exec_alu_op", bus.alu_op, op);
        check("exec_alu_a", bus.alu_a, a);
        check("exec_alu_b", bus.alu_b, b);
        check("exec_done", bus.done, 0);
        @(negedge clk); #1;
        check("wb_done", bus.done, 1);
        check("wb_res_out", bus.res_out, e[7:0]);
        check("wb_alu_op", bus.alu_op, 0);
        check("wb_alu_a", bus.alu_a, 0);
        if (op != 4'd0) begin
            mreg[rd] = e[7:0];
            mflags   = e[11:8];
        end
        @(negedge clk); #1;
        check("idle_done", bus.done, 0);
        check("idle_stat_out", bus.stat_out, mflags);
        check("idle_res_out", bus.res_out, e[7:0]);
        check("idle_cmd_ready", bus.cmd_ready, 1);
        check_reg("wb_reg", rd, mreg[rd]);
    endtask

    initial begin
        int          n_acc;
        int          n_done;
        int          acc_cyc [3];
        logic [11:0] e;

        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'd0;
        bus.cmd_rd    = 2'd0;
        bus.cmd_ra    = 2'd0;
        bus.cmd_rb    = 2'd0;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = 2'd0;
        bus.ld_data   = 8'd0;
        bus.dbg_addr  = 2'd0;
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        mflags = 4'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_ld_ready", bus.ld_ready, 1);
        check("rst_done", bus.done, 0);
        check("rst_alu_op", bus.alu_op, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        check("rst_res_out", bus.res_out, 0);
        check("rst_stat_out", bus.stat_out, 0);
        check_all_regs("rst_reg");

        // Addr r0 = r1 + r2
        do_load(2'd1, 8'h05);
        do_load(2'd2, 8'h03);
        do_cmd(4'd1, 2'd0, 2'd1, 2'd2);
        check("addr_res", bus.res_out, 8'h08);
        check_reg("addr_r0", 2'd0, 8'h08);

        // lAnd r3 = r1 & r2
        do_load(2'd1, 8'hF0);
        do_load(2'd2, 8'h3C);
        do_cmd(4'd7, 2'd3, 2'd1, 2'd2);
        check_reg("land_r3", 2'd3, 8'h30);

        // Noop must not write back
        do_load(2'd0, 8'hAA);
        do_cmd(4'd0, 2'd0, 2'd1, 2'd2);
        check_reg("noop_r0", 2'd0, 8'hAA);

        // Three queued IncL r1 -> r1 with cmd_valid held high
        do_load(2'd1, 8'h05);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'd3;
        bus.cmd_rd    = 2'd1;
        bus.cmd_ra    = 2'd1;
        bus.cmd_rb    = 2'd0;
        n_acc  = 0;
        n_done = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            #1;
            if (bus.done) begin
                check("queue_res", bus.res_out, 8'h05 + 8'(n_done) + 8'h01);
                n_done++;
            end
            if (bus.cmd_valid && bus.cmd_ready && n_acc < 3) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            @(negedge clk);
            if (n_acc == 3) bus.cmd_valid = 1'b0;
        end
        mreg[1] = 8'h08;
        mflags  = alu_eval(4'd3, 8'h07, 8'h00) >> 8;
        check("queue_n_acc", n_acc, 3);
        check("queue_n_done", n_done, 3);
        check("queue_gap1", acc_cyc[1] - acc_cyc[0], 4);
        check("queue_gap2", acc_cyc[2] - acc_cyc[1], 4);
        check_reg("queue_r1", 2'd1, 8'h08);
        check("queue_stat", bus.stat_out, mflags);

        // Load and command requested together: command wins
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 2'd2;
        bus.ld_data   = 8'h77;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'd12;
        bus.cmd_rd    = 2'd0;
        bus.cmd_ra    = 2'd1;
        bus.cmd_rb    = 2'd3;
        #1;
        check("conf_ld_ready", bus.ld_ready, 0);
        check("conf_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1;
        e = alu_eval(4'd12, mreg[1], mreg[3]);
        check("conf_oper_ld_ready", bus.ld_ready, 0);
        check_reg("conf_r2_kept", 2'd2, mreg[2]);
        @(negedge clk); #1;
        check("conf_exec_ld_ready", bus.ld_ready, 0);
        @(negedge clk); #1;
        check("conf_wb_done", bus.done, 1);
        check("conf_wb_ld_ready", bus.ld_ready, 0);
        check_reg("conf_wb_r2_kept", 2'd2, mreg[2]);
        mreg[0] = e[7:0];
        mflags  = e[11:8];
        @(negedge clk); #1;
        check("conf_idle_ld_ready", bus.ld_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        mreg[2]      = 8'h77;
        check_all_regs("conf_regs");

        // Reset during EXEC aborts the command
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'd1;
        bus.cmd_rd    = 2'd3;
        bus.cmd_ra    = 2'd1;
        bus.cmd_rb    = 2'd2;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk); #1;
        check("rexec_alu_op", bus.alu_op, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        mflags = 4'h0;
        #1;
        check("rexec_cmd_ready", bus.cmd_ready, 1);
        check("rexec_res_out", bus.res_out, 0);
        check("rexec_stat_out", bus.stat_out, 0);
        for (int i = 0; i < 4; i++) begin
            check("rexec_done", bus.done, 0);
            @(negedge clk); #1;
        end
        check_all_regs("rexec_regs");

        // Randomized commands and loads against the model
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_load(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            end else begin
                do_cmd(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            end
        end
        check_all_regs("rand_regs");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
